cdc_req_ack_ctrl: RTL and testbench

Source-side sequencer for a toggle-based request/acknowledge clock-domain crossing. It accepts words through a valid/ready port and holds each word stable on `xdata`. It then signals the word to the far domain by toggling `xreq` and waits until the far domain's `xack` toggle returns through an internal LAT-stage synchronizer. It sits next to `cross_clk_sync` instances in multi-clock designs, and it is the block that decides when the crossing bus may change.

---
 rtl/cdc_req_ack_ctrl_if.sv | 25 ++
 rtl/cdc_req_ack_ctrl.sv | 142 ++++++++++++++
 tb/tb_cdc_req_ack_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_req_ack_ctrl_if.sv
// Handshake bundle for cdc_req_ack_ctrl: local valid/ready word port, crossing bus and error flag.
// The slave modport belongs to the controller and the master modport to whatever drives it.
interface cdc_req_ack_ctrl_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] xdata;
    logic             xreq;
    logic             xack;
    logic             busy;
    logic             timeout_err;
    logic             clr_err;

    modport master (
        output in_data, in_valid, xack, clr_err,
        input  in_ready, xdata, xreq, busy, timeout_err
    );

    modport slave (
        input  in_data, in_valid, xack, clr_err,
        output in_ready, xdata, xreq, busy, timeout_err
    );
endinterface

// File: rtl/cdc_req_ack_ctrl.sv
// Source-side sequencer for a toggle request/acknowledge crossing: holds each word on xdata,
// toggles xreq one cycle later and waits for the synchronized xack toggle to match.
module cdc_req_ack_ctrl #(
    parameter int DSIZE   = 8,
    parameter int LAT     = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cdc_req_ack_ctrl_if.slave     bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TMO_M1  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [LAT-1:0]   sync_r;
    logic             ack_s;
    logic [CW-1:0]    cnt_r;
    logic [DSIZE-1:0] xdata_r;
    logic             xreq_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             err_r;
    logic             accept_s;
    logic             toggle_s;
    logic             set_s;

    assign ack_s           = sync_r[LAT-1];
    assign bus.xdata       = xdata_r;
    assign bus.xreq        = xreq_r;
    assign bus.in_ready    = in_ready_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = err_r;

    // Next-state decode and transfer strobes
    always_comb begin
        next_s   = state_r;
        accept_s = 1'b0;
        toggle_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    next_s   = ST_SETUP;
                    accept_s = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                next_s   = ST_WAIT;
                toggle_s = 1'b1;
            end
            ST_WAIT: begin
                if (ack_s == xreq_r) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Error set fires once, on the cycle the saturating count reaches TIMEOUT
    always_comb begin
        set_s = 1'b0;
        if ((TIMEOUT != 0) && (state_r == ST_WAIT) && (cnt_r == TMO_M1)) begin
            set_s = 1'b1;
        end else begin
            set_s = 1'b0;
        end
    end

    // State register; ready/busy are registered copies of the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_s;
            in_ready_r <= (next_s == ST_IDLE);
            busy_r     <= (next_s != ST_IDLE);
        end
    end

    // Crossing bus: data loads on accept, request toggles only on leaving SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xdata_r <= {DSIZE{1'b0}};
            xreq_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                xdata_r <= bus.in_data;
            end
            if (toggle_s) begin
                xreq_r <= ~xreq_r;
            end
        end
    end

    // xack synchronizer; nothing else may sample xack (LAT must be at least 2)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {LAT{1'b0}};
        end else begin
            sync_r <= {sync_r[LAT-2:0], bus.xack};
        end
    end

    // WAIT_ACK cycle counter, cleared on entry and saturating at TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (toggle_s) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_r == ST_WAIT) && (cnt_r != TMO_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Sticky timeout flag; a same-cycle set beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (set_s) begin
            err_r <= 1'b1;
        end else if (bus.clr_err) begin
            err_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdc_req_ack_ctrl.sv
// Directed bench for cdc_req_ack_ctrl with LAT=2, TIMEOUT=8 and a selectable xack source:
// zero-delay loopback, 3-cycle delayed loopback, or a manually driven toggle.
module tb_cdc_req_ack_ctrl;
    localparam int DSIZE = 8;
    localparam int LAT   = 2;
    localparam int TMO   = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         mode   = 0;
    logic       xack_man = 1'b0;
    logic [2:0] dly_r;

    cdc_req_ack_ctrl_if #(.DSIZE(DSIZE)) bus();

    cdc_req_ack_ctrl #(.DSIZE(DSIZE), .LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_r <= 3'b000;
        else        dly_r <= {dly_r[1:0], bus.xreq};
    end

    assign bus.xack = (mode == 0) ? bus.xreq : ((mode == 1) ? dly_r[2] : xack_man);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent;
        int   togg;
        int   last_tog;
        int   cyc;
        int   n;
        int   r;
        logic prev;
        logic acc;
        logic exp_req;
        logic [7:0] w;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.clr_err  = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_xreq", bus.xreq, 0);
        chk("rst_xdata", bus.xdata, 0);
        chk("rst_err", bus.timeout_err, 0);
        tick();

        // single transfer, zero-delay loopback
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        chk("single_xdata", bus.xdata, 8'hA5);
        chk("single_xreq0", bus.xreq, 0);
        chk("single_ready0", bus.in_ready, 0);
        chk("single_busy", bus.busy, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h3C;
        tick();
        chk("single_xreq1", bus.xreq, 1);
        chk("single_hold", bus.xdata, 8'hA5);
        tick();
        tick();
        chk("single_ready_e3", bus.in_ready, 0);
        tick();
        chk("single_ready_e4", bus.in_ready, 1);
        chk("single_idle", bus.busy, 0);

        // streaming 0x01..0x10 through a 3-cycle loopback
        mode = 1;
        repeat (4) tick();
        sent     = 0;
        togg     = 0;
        last_tog = 0;
        cyc      = 0;
        prev     = bus.xreq;
        bus.in_data  = 8'h01;
        bus.in_valid = 1'b1;
        while ((togg < 16 || bus.busy) && cyc < 400) begin
            acc = bus.in_valid & bus.in_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 16) bus.in_data = 8'(sent + 1);
                else           bus.in_valid = 1'b0;
            end
            if (bus.xreq != prev) begin
                chk($sformatf("stream_data%0d", togg), bus.xdata, togg + 1);
                if (togg > 0) chk("stream_gap", cyc - last_tog, 8);
                last_tog = cyc;
                togg++;
                prev = bus.xreq;
            end
        end
        chk("stream_sent", sent, 16);
        chk("stream_toggles", togg, 16);
        chk("stream_idle", bus.busy, 0);
        chk("stream_no_err", bus.timeout_err, 0);

        // timeout with xack stuck
        xack_man = bus.xreq;
        mode = 2;
        repeat (3) tick();
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        chk("tmo_err_e7", bus.timeout_err, 0);
        tick();
        chk("tmo_err_e8", bus.timeout_err, 0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("tmo_set_wins", bus.timeout_err, 1);
        chk("tmo_busy", bus.busy, 1);
        repeat (5) tick();
        chk("tmo_sticky", bus.timeout_err, 1);
        chk("tmo_still_busy", bus.busy, 1);
        chk("tmo_xdata_hold", bus.xdata, 8'h5A);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("tmo_cleared", bus.timeout_err, 0);
        tick();
        chk("tmo_stays_clear", bus.timeout_err, 0);
        xack_man = ~xack_man;
        tick();
        tick();
        chk("tmo_busy_before_ack", bus.busy, 1);
        tick();
        chk("tmo_done_busy", bus.busy, 0);
        chk("tmo_done_ready", bus.in_ready, 1);

        // asynchronous reset in WAIT_ACK with xreq=1
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mid_xreq1", bus.xreq, 1);
        tick();
        chk("mid_busy", bus.busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_xreq", bus.xreq, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_xdata", bus.xdata, 0);
        xack_man = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // randomly phased xack toggles
        exp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 8'hC0 + 8'(i * 17);
            bus.in_data  = w;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            exp_req = ~exp_req;
            chk("jit_xreq", bus.xreq, exp_req);
            r = $urandom_range(0, 2);
            repeat (r) begin
                tick();
                chk("jit_wait_xdata", bus.xdata, w);
                chk("jit_wait_xreq", bus.xreq, exp_req);
            end
            #($urandom_range(1, 8));
            xack_man = ~xack_man;
            n = 0;
            while (bus.busy && n < 10) begin
                tick();
                n++;
                if (bus.busy) begin
                    chk("jit_hold_xdata", bus.xdata, w);
                    chk("jit_hold_xreq", bus.xreq, exp_req);
                end
            end
            chk($sformatf("jit_latency_n%0d", n), (n >= LAT + 1) && (n <= LAT + 2), 1);
        end
        chk("jit_no_err", bus.timeout_err, 0);
        chk("jit_ready", bus.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
